// File: rtl/rr_mux2_stage.sv
// Two-channel round-robin merge into a single output register with registered mux select.
// Define RR_MUX2_FIXED_PRIO_EN for fixed priority (A always wins contention, no fairness state).
module rr_mux2_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;
  logic             load;
  logic             grant_a, grant_b;

`ifdef RR_MUX2_FIXED_PRIO_EN
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid & ~a_valid;
  end
`else
  logic last_q, last_d;

  // last_q = 1 means B was granted most recently, so A wins the next contention.
  always_comb begin
    grant_a = a_valid & (~b_valid | last_q);
    grant_b = b_valid & (~a_valid | ~last_q);
  end

  always_comb begin
    last_d = last_q;
    if (load && (grant_a || grant_b)) last_d = grant_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  always_comb begin
    load    = ~out_valid_q | out_ready;
    a_ready = load & grant_a;
    b_ready = load & grant_b;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      if (grant_a) begin
        out_valid_d = 1'b1;
        out_data_d  = a_data;
        out_sel_d   = 1'b0;
      end else if (grant_b) begin
        out_valid_d = 1'b1;
        out_data_d  = b_data;
        out_sel_d   = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
